// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch MM:SS counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_MAX      = 4'd9;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button, timer-tick and display signals of the stopwatch counter.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic start_stop;
    logic clear;
    logic second_tick;
    logic timer_enable;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
    bcd_t min_tens;
    logic running;
    logic rollover;

    modport slave (
        input  start_stop,
        input  clear,
        input  second_tick,
        output timer_enable,
        output sec_ones,
        output sec_tens,
        output min_ones,
        output min_tens,
        output running,
        output rollover
    );

    modport master (
        output start_stop,
        output clear,
        output second_tick,
        input  timer_enable,
        input  sec_ones,
        input  sec_tens,
        input  min_ones,
        input  min_tens,
        input  running,
        input  rollover
    );

endinterface

// File: rtl/stopwatch_counter_edge_detect.sv
// Rising-edge detector for an already synchronized button level.
module edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic armed;

    // armed stays low for the first edge after reset so a button held through
    // reset release is absorbed into in_q instead of producing an event.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q  <= in;
            armed <= 1'b1;
        end
    end

    assign rise = in & ~in_q & armed;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch run/stop/clear FSM with a BCD MM:SS tick accumulator.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MINUTES = 59
) (
    input  logic                clk,
    input  logic                n_rst,
    stopwatch_counter_if.slave  sw
);

    localparam bcd_t MAX_MIN_TENS = bcd_t'(MAX_MINUTES / 10);
    localparam bcd_t MAX_MIN_ONES = bcd_t'(MAX_MINUTES % 10);

    sw_state_t state;
    bcd_t      sec_ones_q;
    bcd_t      sec_tens_q;
    bcd_t      min_ones_q;
    bcd_t      min_tens_q;
    logic      timer_enable_q;
    logic      running_q;
    logic      rollover_q;

    logic start_ev;
    logic clear_ev;
    logic count_en;
    logic sec_ones_wrap;
    logic sec_tens_wrap;
    logic min_ones_wrap;
    logic at_max_minutes;

    edge_detect u_start_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .in    (sw.start_stop),
        .rise  (start_ev)
    );

    edge_detect u_clear_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .in    (sw.clear),
        .rise  (clear_ev)
    );

    always_comb begin
        count_en       = (state == RUNNING) && sw.second_tick && !clear_ev;
        sec_ones_wrap  = (sec_ones_q == BCD_MAX);
        sec_tens_wrap  = (sec_tens_q == SEC_TENS_MAX);
        min_ones_wrap  = (min_ones_q == BCD_MAX);
        at_max_minutes = (min_tens_q == MAX_MIN_TENS) && (min_ones_q == MAX_MIN_ONES);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            sec_ones_q     <= '0;
            sec_tens_q     <= '0;
            min_ones_q     <= '0;
            min_tens_q     <= '0;
            timer_enable_q <= 1'b0;
            running_q      <= 1'b0;
            rollover_q     <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            if (clear_ev) begin
                state          <= IDLE;
                sec_ones_q     <= '0;
                sec_tens_q     <= '0;
                min_ones_q     <= '0;
                min_tens_q     <= '0;
                timer_enable_q <= 1'b0;
                running_q      <= 1'b0;
            end else begin
                // A tick sampled alongside a stop edge still counts: the
                // increment uses the pre-edge state, the transition follows.
                if (count_en) begin
                    if (!sec_ones_wrap) begin
                        sec_ones_q <= sec_ones_q + 4'd1;
                    end else begin
                        sec_ones_q <= '0;
                        if (!sec_tens_wrap) begin
                            sec_tens_q <= sec_tens_q + 4'd1;
                        end else begin
                            sec_tens_q <= '0;
                            if (at_max_minutes) begin
                                min_ones_q <= '0;
                                min_tens_q <= '0;
                                rollover_q <= 1'b1;
                            end else if (!min_ones_wrap) begin
                                min_ones_q <= min_ones_q + 4'd1;
                            end else begin
                                min_ones_q <= '0;
                                min_tens_q <= min_tens_q + 4'd1;
                            end
                        end
                    end
                end

                if (start_ev) begin
                    case (state)
                        IDLE, STOPPED: begin
                            state          <= RUNNING;
                            timer_enable_q <= 1'b1;
                            running_q      <= 1'b1;
                        end
                        RUNNING: begin
                            state          <= STOPPED;
                            timer_enable_q <= 1'b0;
                            running_q      <= 1'b0;
                        end
                        default: begin
                            state          <= IDLE;
                            timer_enable_q <= 1'b0;
                            running_q      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign sw.timer_enable = timer_enable_q;
    assign sw.running      = running_q;
    assign sw.rollover     = rollover_q;
    assign sw.sec_ones     = sec_ones_q;
    assign sw.sec_tens     = sec_tens_q;
    assign sw.min_ones     = min_ones_q;
    assign sw.min_tens     = min_tens_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic n_rst;

    stopwatch_counter_if sw ();

    stopwatch_counter #(.MAX_MINUTES(59)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        logic [15:0] dig;
        logic        run;
        logic        roll;
    } exp_rec_t;

    exp_rec_t q[$];
    int checks = 0;
    int errors = 0;

    // Total elapsed seconds to {min_tens, min_ones, sec_tens, sec_ones}.
    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(input string nm, input int due, input int t,
                        input logic run, input logic roll);
        exp_rec_t e;
        e.due  = due;
        e.name = nm;
        e.dig  = to_bcd(t);
        e.run  = run;
        e.roll = roll;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; the outcome is expected after the next edge.
    task automatic cyc_drive(input string nm, input logic s, input logic c,
                             input logic t, input int secs,
                             input logic run, input logic roll);
        sw.start_stop  = s;
        sw.clear       = c;
        sw.second_tick = t;
        push(nm, cyc + 1, secs, run, roll);
        step();
    endtask

    always @(negedge clk) begin
        logic [15:0] act;
        exp_rec_t    e;
        act = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc || act !== e.dig || sw.running !== e.run ||
                sw.timer_enable !== e.run || sw.rollover !== e.roll) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d: got %h run=%b en=%b roll=%b, want %h run=%b en=%b roll=%b",
                         e.name, cyc, e.due, act, sw.running, sw.timer_enable,
                         sw.rollover, e.dig, e.run, e.run, e.roll);
            end
        end
    end

    initial begin
        n_rst          = 1'b0;
        sw.start_stop  = 1'b0;
        sw.clear       = 1'b0;
        sw.second_tick = 1'b0;
        step();

        // Reset state
        cyc_drive("reset", 0, 0, 0, 0, 0, 0);
        cyc_drive("reset", 0, 0, 1, 0, 0, 0);
        n_rst = 1'b1;
        cyc_drive("post_reset", 0, 0, 0, 0, 0, 0);

        // Start, then three ticks with one-cycle latency
        cyc_drive("start", 1, 0, 0, 0, 1, 0);
        cyc_drive("start_low", 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc_drive("tick", 0, 0, 1, i, 1, 0);
            cyc_drive("tick_gap", 0, 0, 0, i, 1, 0);
        end

        // Held start_stop gives a single stop; stopped ticks ignored; resume
        for (int i = 0; i < 50; i++) cyc_drive("stop_hold", 1, 0, 0, 3, 0, 0);
        cyc_drive("stop_release", 0, 0, 0, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc_drive("stopped_tick", 0, 0, 1, 3, 0, 0);
            cyc_drive("stopped_gap", 0, 0, 0, 3, 0, 0);
        end
        cyc_drive("resume", 1, 0, 0, 3, 1, 0);
        cyc_drive("resume_low", 0, 0, 0, 3, 1, 0);
        cyc_drive("resume_tick", 0, 0, 1, 4, 1, 0);

        // Tick coincident with stop edge at 00:04 is counted
        cyc_drive("tick_with_stop", 1, 0, 1, 5, 0, 0);
        cyc_drive("tick_stop_low", 0, 0, 0, 5, 0, 0);
        cyc_drive("stopped_tick2", 0, 0, 1, 5, 0, 0);

        // Clear and start together at 00:07 -> IDLE, zeroed
        cyc_drive("resume2", 1, 0, 0, 5, 1, 0);
        cyc_drive("resume2_low", 0, 0, 0, 5, 1, 0);
        cyc_drive("tick6", 0, 0, 1, 6, 1, 0);
        cyc_drive("tick7", 0, 0, 1, 7, 1, 0);
        cyc_drive("clear_and_start", 1, 1, 0, 0, 0, 0);
        cyc_drive("clear_release", 0, 0, 0, 0, 0, 0);
        cyc_drive("idle_tick", 0, 0, 1, 0, 0, 0);
        cyc_drive("start_from_idle", 1, 0, 0, 0, 1, 0);
        cyc_drive("start_from_idle_low", 0, 0, 0, 0, 1, 0);

        // Carry chain through 00:59->01:00 up to 59:59, then wrap
        for (int i = 1; i <= 3599; i++) cyc_drive("count", 0, 0, 1, i, 1, 0);
        cyc_drive("wrap", 0, 0, 1, 0, 1, 1);
        cyc_drive("after_wrap", 0, 0, 0, 0, 1, 0);

        // Count to 12:34, then asynchronous reset between clock edges
        for (int i = 1; i <= 754; i++) cyc_drive("count2", 0, 0, 1, i, 1, 0);
        sw.second_tick = 1'b0;
        step();
        #2;
        n_rst         = 1'b0;
        sw.start_stop = 1'b1;
        push("async_reset", cyc, 0, 0, 0);
        step();
        cyc_drive("in_reset", 1, 0, 0, 0, 0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc_drive("held_after_reset", 1, 0, 0, 0, 0, 0);
        cyc_drive("lowered", 0, 0, 0, 0, 0, 0);
        cyc_drive("reraised", 1, 0, 0, 0, 1, 0);
        cyc_drive("reraised_low", 0, 0, 0, 0, 1, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Consumer side of the timer's second_tick interface. It owns the stopwatch run/stop/clear state machine, drives the timer's enable, and accumulates ticks into a BCD MM:SS count for the display path. It sits between the button front end (already synchronized) and the timer/seven-segment blocks.

Parameters:
MAX_MINUTES, 59, highest minute value before the count wraps to 00:00 (legal range 1..99).

Ports:
clk  input  1  system clock, same domain as timer.
n_rst  input  1  asynchronous active-low reset.
start_stop  input  1  synchronized level from button; a rising edge toggles run/stop.
clear  input  1  synchronized level from button; a rising edge returns to IDLE and zeroes the count.
second_tick  input  1  one-cycle pulse from timer, valid only while timer_enable=1.
timer_enable  output  1  drives timer.enable; 1 only in RUNNING.
sec_ones  output  4  BCD seconds units, 0..9.
sec_tens  output  4  BCD seconds tens, 0..5.
min_ones  output  4  BCD minutes units, 0..9.
min_tens  output  4  BCD minutes tens, 0..9.
running  output  1  1 when state is RUNNING.
rollover  output  1  one-cycle pulse when the count wraps from MAX_MINUTES:59 to 00:00.

Behaviour:
- Reset (n_rst=0, asynchronous) sets state=IDLE, all BCD digits=0, timer_enable=0, running=0, rollover=0, and the edge-detect history registers=0.
- Edge detection: each button is registered once. An event is btn & ~btn_q. A button held high produces exactly one event. A button already high when reset is released produces no event.
- FSM states are IDLE, RUNNING and STOPPED:
  - IDLE + start event -> RUNNING.
  - RUNNING + start event -> STOPPED.
  - STOPPED + start event -> RUNNING, and the count resumes from its held value.
  - Clear event in any state -> IDLE, with all digits set to 0 on the same edge.
  - Clear and start events in the same cycle: clear wins, and the next state is IDLE.
- timer_enable and running are registered from the state: both equal 1 in the cycle after the edge that enters RUNNING, and both equal 0 in the cycle after the edge that leaves it.
- Counting:
  - second_tick is sampled on the rising clk edge. The count increments only if the current state is RUNNING and no clear event is present. The new value is visible the following cycle (1-cycle latency).
  - A tick arriving in the same cycle as a stop event is counted, because state was still RUNNING when it was sampled.
  - Ticks seen in IDLE or STOPPED are ignored.
- BCD carry chain:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into the minutes.
  - The minutes form one BCD pair: min_ones 9 -> 0 carries into min_tens.
  - When {min_tens,min_ones} equals MAX_MINUTES and the seconds are 59, a tick wraps all digits to 0 and pulses rollover for exactly 1 cycle. The state stays RUNNING.
- No digit ever holds a non-BCD value. Every output is driven directly from a register, with no combinational path from inputs to outputs.

Decomposition:
- stopwatch_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} sw_state_t;
  - localparam SEC_TENS_MAX=5;
  - localparam BCD_MAX=9;
  - typedef logic [3:0] bcd_t.
- One sub-module, edge_detect (clk, n_rst, in, rise), instantiated twice, once for start_stop and once for clear.

Test Plan:
1. Release reset, pulse start_stop, apply 3 second_tick pulses -> running=1 and timer_enable=1 one cycle after the start edge; the digits read 00:03, and each increment appears 1 cycle after its tick.
2. Hold start_stop high for 50 cycles while RUNNING -> exactly one transition to STOPPED. A further 5 ticks leave the count at its held value. A second start edge resumes counting from that value.
3. Preload by ticking to 00:59, then apply 1 tick -> 01:00. Tick on to MAX_MINUTES:59 (59:59), then apply 1 tick -> 00:00, rollover high for exactly 1 cycle, state still RUNNING.
4. Raise start_stop and clear in the same cycle while RUNNING at 00:07 -> the next state is IDLE, all digits are 0, and timer_enable=0.
5. Assert a tick in the same cycle as a stop edge at 00:04 -> the count reads 00:05 and the state is STOPPED.
6. Assert n_rst low mid-count at 12:34, asynchronously between clock edges -> outputs go to 0 and IDLE immediately, without waiting for a clock edge. After release, holding start_stop high produces no event until it is lowered and raised again.
